// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: owns the imem port, passes CPU fetch
// addresses through when idle and writes a big-endian word stream when loading.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin a load (sampled only while idle)
//   rx_data/valid/ready byte stream handshake, transfer on valid && ready
//   cpu_addr            CPU fetch byte address (passed through when idle)
//   cpu_stall, busy     high whenever a load is in progress
//   mem_addr/wdata/we   instruction memory port
//   done                one-cycle pulse on successful completion
//   err                 sticky oversize-header error, cleared by next start
//   loaded_words        word count of the last successful load
module imem_boot_loader #(
  parameter int unsigned          DEPTH     = 128,
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       loaded_words
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [31:0] word_q, word_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] loaded_q, loaded_d;
  logic        err_q, err_d;

  logic        xfer;
  logic [15:0] hdr;
  logic [ADDR_W-1:0] load_addr;

  assign xfer = rx_valid && rx_ready;
  assign hdr  = {count_q[15:8], rx_data};
  // Byte offset of the current word; wraps modulo 2^ADDR_W.
  assign load_addr = BASE_ADDR + ADDR_W'({word_idx_q, 2'b00});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      word_q     <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      loaded_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_q     <= word_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_d     = word_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    loaded_d   = loaded_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR0;
          err_d      = 1'b0;
          word_idx_d = '0;
          byte_idx_d = '0;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          count_d[15:8] = rx_data;
          state_d       = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          count_d[7:0] = rx_data;
          if (hdr == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, hdr} > DEPTH_L) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d     = {word_q[23:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_q == count_q - 16'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        loaded_d = count_q;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    cpu_stall = 1'b1;
    mem_addr  = load_addr;
    unique case (state_q)
      S_IDLE: begin
        cpu_stall = 1'b0;
        mem_addr  = cpu_addr;
      end
      S_HDR0, S_HDR1, S_DATA: begin
        rx_ready = 1'b1;
      end
      S_WRITE: begin
        mem_we = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        rx_ready = 1'b0;
      end
    endcase
  end

  assign busy         = cpu_stall;
  assign mem_wdata    = word_q;
  assign err          = err_q;
  assign loaded_words = loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader.
// Expected writes come from a queue model built from each generated stream.
module tb_imem_boot_loader;

  localparam int DEPTH = 128;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] cpu_addr;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] loaded_words;

  imem_boot_loader #(
    .DEPTH(DEPTH),
    .ADDR_W(32),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .cpu_addr(cpu_addr),
    .cpu_stall(cpu_stall),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .busy(busy),
    .done(done),
    .err(err),
    .loaded_words(loaded_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_we_cyc = 0;
  int model_loaded = 0;
  logic [31:0] eq_addr[$];
  logic [31:0] eq_data[$];
  logic [31:0] fixed_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      last_we_cyc = cyc;
      if (eq_addr.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        chk("we_addr", mem_addr, eq_addr.pop_front());
        chk("we_data", mem_wdata, eq_data.pop_front());
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_load(output int s);
    rx_valid = 1'b0;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("stall_hi", 32'(cpu_stall), 32'd1);
    chk("busy_hi", 32'(busy), 32'd1);
    chk("err_clr", 32'(err), 32'd0);
  endtask

  // gmode: 0 back-to-back, 1 one idle cycle per byte, 2 random gaps
  task automatic send_byte(input logic [7:0] b, input int gmode,
                           input bit mid_start);
    int g;
    int t;
    g = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 2));
    repeat (g) begin
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      start = mid_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    rx_valid = 1'b1;
    rx_data = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (rx_ready !== 1'b1) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_load(input logic [15:0] hdr, input int gmode,
                          input bit mid_start, input bit fixed);
    int s;
    int d0;
    int t;
    bit legal;
    logic [31:0] w;
    legal = (int'(hdr) <= DEPTH);
    start_load(s);
    d0 = done_cnt;
    send_byte(hdr[15:8], gmode, mid_start);
    send_byte(hdr[7:0], gmode, mid_start);
    if (legal) begin
      for (int i = 0; i < int'(hdr); i++) begin
        w = fixed ? fixed_q.pop_front() : $urandom;
        eq_addr.push_back(32'(i * 4));
        eq_data.push_back(w);
        send_byte(w[31:24], gmode, mid_start);
        send_byte(w[23:16], gmode, mid_start);
        send_byte(w[15:8], gmode, mid_start);
        send_byte(w[7:0], gmode, mid_start);
      end
    end
    t = 0;
    while (done !== 1'b1 && err !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("end_seen", 32'(done | err), 32'd1);
    @(negedge clk);
    chk("done_pulses", 32'(done_cnt - d0), legal ? 32'd1 : 32'd0);
    chk("err_state", 32'(err), legal ? 32'd0 : 32'd1);
    if (legal) model_loaded = int'(hdr);
    chk("loaded_words", 32'(loaded_words), 32'(model_loaded));
    chk("idle_after", 32'(cpu_stall), 32'd0);
    chk("writes_left", 32'(eq_addr.size()), 32'd0);
    if (legal && gmode == 0)
      chk("load_cycles", 32'(done_cyc - s), 32'(3 + 5 * int'(hdr)));
    if (legal && hdr != 16'd0)
      chk("done_after_we", 32'(done_cyc - last_we_cyc), 32'd1);
    eq_addr.delete();
    eq_data.delete();
  endtask

  initial begin
    int s;
    logic [31:0] w0;
    logic [31:0] w1;
    int d0;
    rst_n = 1'b0;
    start = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    cpu_addr = 32'h1234_5678;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_loaded", 32'(loaded_words), 32'd0);
    chk("rst_addr", mem_addr, 32'h1234_5678);
    start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cpu_addr = (i == 0) ? 32'h10 : $urandom;
      rx_data = 8'($urandom);
      @(negedge clk);
      chk("pass_addr", mem_addr, cpu_addr);
      chk("pass_we", 32'(mem_we), 32'd0);
      chk("pass_ready", 32'(rx_ready), 32'd0);
    end
    rx_valid = 1'b0;

    fixed_q = '{32'h2008_0005, 32'hAC09_0004};
    run_load(16'd2, 0, 1'b0, 1'b1);
    fixed_q = '{32'h2008_0005, 32'hAC09_0004};
    run_load(16'd2, 1, 1'b1, 1'b1);

    run_load(16'd0, 0, 1'b0, 1'b0);
    run_load(16'h0081, 0, 1'b0, 1'b0);
    run_load(16'($urandom_range(129, 65535)), 2, 1'b1, 1'b0);
    run_load(16'd1, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++)
      run_load(16'($urandom_range(1, 8)), k % 3, k[0], 1'b0);

    run_load(16'(DEPTH), 0, 1'b0, 1'b0);

    start_load(s);
    w0 = $urandom;
    w1 = $urandom;
    eq_addr.push_back(32'h0);
    eq_data.push_back(w0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(w0[31:24], 0, 1'b0);
    send_byte(w0[23:16], 0, 1'b0);
    send_byte(w0[15:8], 0, 1'b0);
    send_byte(w0[7:0], 0, 1'b0);
    send_byte(w1[31:24], 0, 1'b0);
    send_byte(w1[23:16], 0, 1'b0);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_idle", 32'(busy), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_loaded", 32'(loaded_words), 32'd0);
    rst_n = 1'b1;
    model_loaded = 0;
    rx_valid = 1'b1;
    rx_data = w1[15:8];
    repeat (10) @(negedge clk);
    chk("midrst_ready", 32'(rx_ready), 32'd0);
    chk("midrst_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_writes", 32'(eq_addr.size()), 32'd0);
    run_load(16'd1, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Controller that owns the instruction-memory write/read port and sequences program loading into it from an 8-bit byte stream (UART/debug front end).
- While idle, the CPU fetch address passes straight through to the memory.
- While loading, the CPU is stalled. The block parses a 2-byte word-count header, assembles big-endian 32-bit words and writes them to consecutive word addresses.
- Sits between the fetch stage / PC and Instruction_Memory.

Parameters:
DEPTH, 128, number of 32-bit words in instruction memory (maximum legal word count)
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word
ADDR_W, 32, width of byte addresses

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request to begin a load; sampled only in IDLE
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  block accepts a byte this cycle; transfer when rx_valid && rx_ready
cpu_addr  input  ADDR_W  CPU fetch byte address
cpu_stall  output  1  high whenever state != IDLE
mem_addr  output  ADDR_W  address to instruction memory
mem_wdata  output  32  write data to instruction memory
mem_we  output  1  write enable, one cycle per word
busy  output  1  same as cpu_stall
done  output  1  one-cycle pulse on successful load completion
err  output  1  sticky error; cleared on next accepted start or reset
loaded_words  output  16  word count of last successful load

Behaviour:
Reset (rst_n=0 at a clk edge):
- state=IDLE; word/byte counters, count, assembly register, loaded_words all 0.
- done=0, err=0, mem_we=0, rx_ready=0, cpu_stall=busy=0.

All outputs are Moore-decoded from registered state and counters. There is no combinational path from rx_* to mem_* or from rx_valid to rx_ready.

States and transitions:
- IDLE:
  - mem_addr=cpu_addr (combinational pass-through), mem_we=0, rx_ready=0.
  - start=1 -> HDR0; err cleared; word_idx, byte_idx cleared.
- HDR0:
  - rx_ready=1.
  - On transfer: count[15:8]=rx_data -> HDR1.
- HDR1:
  - rx_ready=1.
  - On transfer: count[7:0]=rx_data. Next state is chosen from the full 16-bit value {count[15:8], rx_data}:
    - 0 -> DONE
    - greater than DEPTH -> ERR
    - otherwise -> DATA
- DATA:
  - rx_ready=1.
  - Each transfer: word={word[23:0],rx_data}, byte_idx++. First byte received lands in bits [31:24].
  - The transfer with byte_idx==3 -> WRITE, byte_idx=0.
- WRITE (exactly 1 cycle):
  - rx_ready=0, mem_we=1, mem_wdata=word, mem_addr=BASE_ADDR+(word_idx<<2).
  - word_idx++.
  - If word_idx==count-1 -> DONE, else -> DATA.
- DONE (1 cycle):
  - done=1, loaded_words=count -> IDLE.
- ERR (1 cycle):
  - err set (stays high in IDLE) -> IDLE.
  - No memory write ever occurs for an oversize header.

Boundary conditions and timing:
- mem_addr in HDR0/HDR1/DATA/DONE/ERR = BASE_ADDR+(word_idx<<2) with mem_we=0. The CPU is stalled, so fetch data is don't-care.
- Throughput: with rx_valid held high, one word takes 5 cycles (4 accept + 1 write).
- Total load time = 2 + 5N cycles from HDR0 entry to DONE, plus 1 DONE cycle.
- rx_valid gaps stall the FSM in its current state with no side effects. rx_data is sampled only on transfer.
- start while busy: ignored. start held high across DONE: a new load begins on the first IDLE cycle.
- rx_valid while IDLE: not accepted (rx_ready=0); bytes are not consumed.
- Reset mid-load:
  - Next cycle is IDLE, with no further writes.
  - Words already written stay in memory. A partially assembled word is discarded.
  - done is not pulsed, loaded_words is unchanged (0 after reset), and err is cleared.
- N == DEPTH: the last write goes to BASE_ADDR+4*(DEPTH-1). Legal.
- Arithmetic: word_idx is 16 bits. mem_addr is computed modulo 2^ADDR_W.

Test Plan:
1. Reset: hold rst_n=0 two cycles with start=1, rx_valid=1 -> cpu_stall=0, rx_ready=0, mem_we=0, done=0, err=0, loaded_words=0, mem_addr==cpu_addr.
2. Pass-through: IDLE, cpu_addr=0x0000_0010 -> mem_addr=0x10, mem_we=0 every cycle; rx_valid=1 bytes are not accepted.
3. Two-word load, back-to-back bytes 00 02 20 08 00 05 AC 09 00 04 after start pulse:
   - mem_we pulses twice: (0x0, 0x20080005), then 5 cycles later (0x4, 0xAC090004).
   - done pulses one cycle after the second write; loaded_words=2.
   - cpu_stall is high from the cycle after start until IDLE returns.
4. Flow control: same stream with rx_valid low every other cycle -> identical writes and order, each write delayed accordingly; start pulses mid-load are ignored.
5. Header edges:
   - 00 00 -> done with no mem_we and loaded_words=0.
   - 00 81 (129 > 128) -> err sticky, no mem_we, loaded_words unchanged.
   - Next start clears err.
6. Reset mid-load: rst_n=0 after the 2nd data byte of word 1 (word 0 already written) -> IDLE next cycle, no further mem_we, done never pulses, a new load then starts cleanly at address 0.
